// File: rtl/multicycle_sequencer_pkg.sv
// Shared sequencer definitions: phase encodings (legacy values), phase width
// and the wait-state counter width. The top level and debug logic import this.
package multicycle_sequencer_pkg;

    localparam int PHASE_W = 4;
    localparam int WAIT_W  = 4;

    typedef enum logic [PHASE_W-1:0] {
        PH_IF    = 4'd0,
        PH_ID    = 4'd1,
        PH_EX    = 4'd2,
        PH_MEM   = 4'd3,
        PH_WB    = 4'd4,
        PH_EXW   = 4'd5,
        PH_WBW   = 4'd6,
        PH_PC    = 4'd8,
        PH_HALT  = 4'd9,
        PH_STEPW = 4'd10
    } phase_t;

    // Value loaded into the wait counter on entry to a wait phase; the
    // counter then spends w cycles in that phase (counting w-1 down to 0).
    function automatic logic [WAIT_W-1:0] wait_load(input int unsigned w);
        return (w > 0) ? WAIT_W'(w - 1) : '0;
    endfunction

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Sequencer <-> datapath bundle: decoded instruction info, the data memory
// handshake and the phase strobes. master = sequencer, slave = datapath.
interface multicycle_sequencer_if
    import multicycle_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) ();

    logic [XLEN-1:0]    instr;
    logic               is_mem;
    logic               mem_ready;
    logic [PHASE_W-1:0] phase;
    logic               en_fetch;
    logic               en_decode;
    logic               en_exec;
    logic               en_wb;
    logic               en_pc;
    logic               mem_req;

    modport master (
        input  instr, is_mem, mem_ready,
        output phase, en_fetch, en_decode, en_exec, en_wb, en_pc, mem_req
    );

    modport slave (
        output instr, is_mem, mem_ready,
        input  phase, en_fetch, en_decode, en_exec, en_wb, en_pc, mem_req
    );

endinterface

// File: rtl/multicycle_sequencer_phase_wait_counter.sv
// Loadable 4-bit down-counter shared by the EX and WB wait phases.
// Load wins over decrement; the count stops at zero.
module phase_wait_counter
    import multicycle_sequencer_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [WAIT_W-1:0] load_val,
    input  logic              en,
    output logic              zero
);

    logic [WAIT_W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (en && (count_reg != '0)) begin
            count_reg <= count_reg - WAIT_W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 phase sequencer with configurable EX/WB wait states,
// memory handshake, single-step, run/freeze, resumable halt and counters.
module multicycle_sequencer
    import multicycle_sequencer_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int EX_WAIT = 2,
    parameter int WB_WAIT = 2,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   run,
    input  logic                   step_mode,
    input  logic                   step_req,
    input  logic                   resume,
    multicycle_sequencer_if.master bus,
    output logic                   halted,
    output logic [CNT_W-1:0]       cycle_cnt,
    output logic [CNT_W-1:0]       retired_cnt
);

    localparam logic [WAIT_W-1:0] EX_LOAD   = wait_load(EX_WAIT);
    localparam logic [WAIT_W-1:0] WB_LOAD   = wait_load(WB_WAIT);
    localparam logic [XLEN-1:0]   ZERO_INSN = '0;

    phase_t            state_reg, state_next;
    logic [CNT_W-1:0]  cycle_reg, retired_reg;
    logic              wait_load_en;
    logic [WAIT_W-1:0] wait_load_val;
    logic              wait_dec;
    logic              wait_zero;

    phase_wait_counter u_wait (
        .clk      (clk),
        .rst      (rst),
        .load     (wait_load_en),
        .load_val (wait_load_val),
        .en       (wait_dec),
        .zero     (wait_zero)
    );

    // Frozen (run=0) cycles hold state and both counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= PH_IF;
            cycle_reg   <= '0;
            retired_reg <= '0;
        end else if (run) begin
            state_reg <= state_next;
            if (state_reg != PH_HALT) begin
                cycle_reg <= cycle_reg + CNT_W'(1);
            end
            if (state_reg == PH_PC) begin
                retired_reg <= retired_reg + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_next    = state_reg;
        wait_load_en  = 1'b0;
        wait_load_val = EX_LOAD;
        wait_dec      = 1'b0;
        bus.en_fetch  = 1'b0;
        bus.en_decode = 1'b0;
        bus.en_exec   = 1'b0;
        bus.en_wb     = 1'b0;
        bus.en_pc     = 1'b0;
        bus.mem_req   = 1'b0;

        case (state_reg)
            PH_IF: begin
                state_next   = PH_ID;
                bus.en_fetch = run;
            end
            PH_ID: begin
                state_next    = (bus.instr == ZERO_INSN) ? PH_HALT : PH_EX;
                bus.en_decode = run;
            end
            PH_EX: begin
                state_next    = (EX_WAIT > 0) ? PH_EXW : PH_MEM;
                wait_load_en  = run && (EX_WAIT > 0);
                wait_load_val = EX_LOAD;
                bus.en_exec   = run;
            end
            PH_EXW: begin
                if (wait_zero) state_next = PH_MEM;
                wait_dec = run && !wait_zero;
            end
            PH_MEM: begin
                // mem_ready is only consulted for loads/stores; it may
                // already be high in the first MEM cycle.
                if (!bus.is_mem || bus.mem_ready) state_next = PH_WB;
                bus.mem_req = bus.is_mem && run;
            end
            PH_WB: begin
                state_next    = (WB_WAIT > 0) ? PH_WBW : PH_PC;
                wait_load_en  = run && (WB_WAIT > 0);
                wait_load_val = WB_LOAD;
                bus.en_wb     = run;
            end
            PH_WBW: begin
                if (wait_zero) state_next = PH_PC;
                wait_dec = run && !wait_zero;
            end
            PH_PC: begin
                state_next = step_mode ? PH_STEPW : PH_IF;
                bus.en_pc  = run;
            end
            PH_STEPW: begin
                if (step_req || !step_mode) state_next = PH_IF;
            end
            PH_HALT: begin
                if (resume) state_next = PH_IF;
            end
            default: begin
                state_next = PH_IF;
            end
        endcase
    end

    assign bus.phase   = state_reg;
    assign halted      = (state_reg == PH_HALT);
    assign cycle_cnt   = cycle_reg;
    assign retired_cnt = retired_reg;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Scoreboard bench: stimulus pushes hand-written expected phases per cycle,
// a negedge monitor pops and compares against both sequencer builds.
module tb_multicycle_sequencer;

    typedef struct {
        logic [3:0]  ph;
        logic        run;
        logic        is_mem;
        int unsigned cyc;
        int unsigned ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0 = 1'b1;
    logic        rst1 = 1'b1;
    logic        run = 1'b1;
    logic        step_mode = 1'b0;
    logic        step_req = 1'b0;
    logic        resume = 1'b0;
    logic [31:0] instr = 32'h0050_0093;
    logic        is_mem = 1'b0;
    logic        mem_ready = 1'b0;

    logic        halted0, halted1;
    logic [31:0] cycle0, retired0;
    logic [3:0]  cycle1, retired1;

    exp_t        q0[$];
    exp_t        q1[$];
    int unsigned exp_cyc[2];
    int unsigned exp_ret[2];
    int          total = 0;
    int          bad = 0;

    int addi_seq[10] = '{0, 1, 2, 5, 5, 3, 4, 6, 6, 8};
    int fast_seq[6]  = '{0, 1, 2, 3, 4, 8};

    always #5 clk = ~clk;

    multicycle_sequencer_if #(.XLEN(32)) bus0 ();
    multicycle_sequencer_if #(.XLEN(32)) bus1 ();

    assign bus0.instr     = instr;
    assign bus0.is_mem    = is_mem;
    assign bus0.mem_ready = mem_ready;
    assign bus1.instr     = instr;
    assign bus1.is_mem    = is_mem;
    assign bus1.mem_ready = mem_ready;

    multicycle_sequencer dut0 (
        .clk         (clk),
        .rst         (rst0),
        .run         (run),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .resume      (resume),
        .bus         (bus0.master),
        .halted      (halted0),
        .cycle_cnt   (cycle0),
        .retired_cnt (retired0)
    );

    multicycle_sequencer #(.EX_WAIT(0), .WB_WAIT(0), .CNT_W(4)) dut1 (
        .clk         (clk),
        .rst         (rst1),
        .run         (run),
        .step_mode   (step_mode),
        .step_req    (step_req),
        .resume      (resume),
        .bus         (bus1.master),
        .halted      (halted1),
        .cycle_cnt   (cycle1),
        .retired_cnt (retired1)
    );

    // Strobe vector {fetch, decode, exec, wb, pc, mem_req, halted} from phase.
    function automatic logic [6:0] exp_strb(input logic [3:0] ph, input logic r, input logic m);
        return {ph == 4'd0 && r, ph == 4'd1 && r, ph == 4'd2 && r, ph == 4'd4 && r,
                ph == 4'd8 && r, ph == 4'd3 && m && r, ph == 4'd9};
    endfunction

    task automatic check(input string name, input int sel, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s dut%0d t=%0t actual=0x%0h required=0x%0h", name, sel, $time, act, req);
        end
    endtask

    // One cycle of stimulus: the caller has set the inputs for this cycle.
    task automatic cyc(input int sel, input int ph);
        exp_t e;
        logic r;
        e.ph     = 4'(ph);
        e.run    = run;
        e.is_mem = is_mem;
        e.cyc    = exp_cyc[sel];
        e.ret    = exp_ret[sel];
        if (sel == 0) q0.push_back(e);
        else          q1.push_back(e);
        r = (sel == 0) ? rst0 : rst1;
        @(posedge clk);
        #1;
        if (r) begin
            exp_cyc[sel] = 0;
            exp_ret[sel] = 0;
        end else if (run) begin
            if (ph != 9) exp_cyc[sel]++;
            if (ph == 8) exp_ret[sel]++;
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0) begin
            e = q0.pop_front();
            check("phase", 0, {28'b0, bus0.phase}, {28'b0, e.ph});
            check("strobes", 0, {25'b0, bus0.en_fetch, bus0.en_decode, bus0.en_exec, bus0.en_wb,
                                 bus0.en_pc, bus0.mem_req, halted0},
                  {25'b0, exp_strb(e.ph, e.run, e.is_mem)});
            check("cycle_cnt", 0, cycle0, e.cyc);
            check("retired_cnt", 0, retired0, e.ret);
            if (bus0.en_pc)
                $display("dut0 retire: retired_cnt=%0d cycle_cnt=%0d", retired0, cycle0);
        end
        if (q1.size() > 0) begin
            e = q1.pop_front();
            check("phase", 1, {28'b0, bus1.phase}, {28'b0, e.ph});
            check("strobes", 1, {25'b0, bus1.en_fetch, bus1.en_decode, bus1.en_exec, bus1.en_wb,
                                 bus1.en_pc, bus1.mem_req, halted1},
                  {25'b0, exp_strb(e.ph, e.run, e.is_mem)});
            check("cycle_cnt", 1, {28'b0, cycle1}, e.cyc & 32'hF);
            check("retired_cnt", 1, {28'b0, retired1}, e.ret & 32'hF);
            if (bus1.en_pc)
                $display("dut1 retire: retired_cnt=%0d cycle_cnt=%0d", retired1, cycle1);
        end
    end

    initial begin
        exp_cyc = '{0, 0};
        exp_ret = '{0, 0};
        @(posedge clk);
        #1;
        cyc(0, 0);                  // still in reset: IF, counters 0, en_fetch=run
        rst0 = 1'b0;

        // addi, default waits: 10 cycles, retires once
        foreach (addi_seq[i]) cyc(0, addi_seq[i]);

        // load: mem_ready low for 3 MEM cycles, high in the 4th
        is_mem = 1'b1;
        for (int i = 0; i < 5; i++) cyc(0, addi_seq[i]);
        for (int i = 0; i < 3; i++) cyc(0, 3);
        mem_ready = 1'b1;
        cyc(0, 3);
        mem_ready = 1'b0;
        cyc(0, 4);
        cyc(0, 6);
        cyc(0, 6);
        cyc(0, 8);
        is_mem = 1'b0;

        // zero instruction halts; resume pulse returns to IF
        instr = 32'h0;
        cyc(0, 0);
        cyc(0, 1);
        for (int i = 0; i < 5; i++) cyc(0, 9);
        resume = 1'b1;
        cyc(0, 9);
        resume = 1'b0;
        instr = 32'h0050_0093;

        // single-step: park in STEPW until step_req
        step_mode = 1'b1;
        foreach (addi_seq[i]) cyc(0, addi_seq[i]);
        for (int i = 0; i < 7; i++) cyc(0, 10);
        step_req = 1'b1;
        cyc(0, 10);
        step_req = 1'b0;
        step_mode = 1'b0;

        // freeze for 4 cycles in the first EXW cycle (counter=1)
        cyc(0, 0);
        cyc(0, 1);
        cyc(0, 2);
        run = 1'b0;
        for (int i = 0; i < 4; i++) cyc(0, 5);
        run = 1'b1;
        for (int i = 3; i < 10; i++) cyc(0, addi_seq[i]);

        // reset while MEM waits on mem_ready
        is_mem = 1'b1;
        for (int i = 0; i < 6; i++) cyc(0, addi_seq[i]);
        rst0 = 1'b1;
        cyc(0, 3);
        rst0 = 1'b0;
        is_mem = 1'b0;
        cyc(0, 0);
        cyc(0, 1);
        rst0 = 1'b1;

        // zero-wait build with 4-bit counters: 17 instructions, retired wraps to 1
        cyc(1, 0);
        rst1 = 1'b0;
        for (int n = 0; n < 17; n++)
            foreach (fast_seq[i]) cyc(1, fast_seq[i]);
        cyc(1, 0);

        for (int i = 0; i < 10 && (q0.size() + q1.size()) > 0; i++) @(negedge clk);
        total++;
        if ((q0.size() + q1.size()) != 0) begin
            bad++;
            $display("FAIL drain actual=%0d required=0 pending entries", q0.size() + q1.size());
        end
        #2;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
- Parametrised control sequencer for the multi-cycle RV32 datapath. It replaces the fixed hard-coded phase FSM in the top level.
- It sequences the IF, ID, EX, MEM, WB and PC-update phases.
- EX and WB wait-state counts are configurable, replacing the fixed auxiliary delay states.
- New relative to the current FSM: a memory ready handshake, single-step mode, run/freeze control, resumable halt on a zero instruction, and cycle and retired-instruction counters.

Parameters:
- XLEN, 32, instruction width.
- EX_WAIT, 2, wait cycles after EX (0..15; 0 = no wait state).
- WB_WAIT, 2, wait cycles after WB (0..15; 0 = no wait state).
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset.
- run  in  1  1 = advance; 0 = freeze state, wait counter and counters.
- instr  in  XLEN  current instruction from instruction memory, valid in ID.
- is_mem  in  1  decoded load/store flag, valid from ID onward.
- mem_ready  in  1  data memory completion handshake.
- step_mode  in  1  single-step enable.
- step_req  in  1  single-step advance request.
- resume  in  1  leave HALT.
- phase  out  4  current state encoding.
- en_fetch, en_decode, en_exec, en_wb, en_pc  out  1 each  phase strobes.
- mem_req  out  1  data memory request.
- halted  out  1  core stopped on a zero instruction.
- cycle_cnt  out  CNT_W  active cycle count.
- retired_cnt  out  CNT_W  completed instruction count.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is synchronous and active-high.
- On rst: phase=IF, wait counter=0, cycle_cnt=0, retired_cnt=0, halted=0. All strobes and mem_req are combinational from phase and run, so they read 0 except en_fetch=run.
- rst mid-operation (including while MEM is waiting on mem_ready) overrides everything.

States and encodings (legacy values preserved):
- IF=0, ID=1, EX=2, MEM=3, WB=4, EXW=5, WBW=6, PC=8, HALT=9, STEPW=10.

Transitions (only when run=1; run=0 holds all state):
- IF -> ID.
- ID -> HALT if instr==0, else EX.
- EX -> EXW if EX_WAIT>0, else MEM. EX loads wait counter = EX_WAIT-1.
- EXW: if counter==0 -> MEM, else decrement.
- MEM: if is_mem=0 -> WB after 1 cycle. If is_mem=1, stay until mem_ready=1 is sampled, then -> WB. A mem_ready high in the first MEM cycle completes in 1 cycle.
- WB -> WBW or PC, following the same rule as EX using WB_WAIT.
- PC -> STEPW if step_mode=1, else IF.
- STEPW -> IF when step_req=1 or step_mode=0; otherwise hold.
- HALT -> IF when resume=1; otherwise hold. halted=1 exactly while phase==HALT.

Output strobes:
- en_fetch=(IF)&run, en_decode=(ID)&run, en_exec=(EX)&run, en_wb=(WB)&run, en_pc=(PC)&run.
- mem_req=(MEM)&is_mem&run, held high for the whole wait.
- Wait states, STEPW and HALT assert no strobe.

Counters:
- cycle_cnt increments every cycle with run=1 and phase not HALT.
- retired_cnt increments on each cycle with en_pc=1.
- Both wrap modulo 2^CNT_W with no saturation.

Latency:
- Non-memory instruction: 6+EX_WAIT+WB_WAIT cycles (10 with defaults, identical to the current FSM).
- Memory instruction: add (N-1), where N is the MEM cycle in which mem_ready is first high.

Simultaneous events:
- rst beats everything.
- run=0 beats step_req and resume; those inputs are level-sampled and are not latched while frozen.
- resume and rst together -> IF via reset.

Decomposition:
- Shared definitions header seq_defs holds the state encoding localparams (IF..STEPW) and the phase width. The top level and debug logic reuse it.
- One sub-module, phase_wait_counter: 4-bit loadable down-counter with load, enable and zero flag. It is instantiated once and shared by EXW and WBW.

Test Plan:
- Reset, run=1, instr=0x00500093 (addi), is_mem=0, defaults -> phase sequence 0,1,2,5,5,3,4,6,6,8,0. en_pc pulses once at cycle 10. retired_cnt=1, cycle_cnt=10.
- Load with is_mem=1, mem_ready held low 3 MEM cycles then high -> mem_req high 4 cycles, total latency 13, en_wb the cycle after mem_ready.
- instr=0 in ID -> phase=9, halted=1, cycle_cnt frozen for 5 cycles. Then resume pulse -> phase=0, halted=0.
- step_mode=1 -> after PC, phase=10 held 7 cycles with no strobes. step_req pulse -> IF next cycle, retired_cnt +1 only.
- run=0 for 4 cycles while in EXW with counter=1 -> phase, counter and cycle_cnt unchanged, strobes 0. On run=1, exits EXW after 2 cycles.
- Build with EX_WAIT=0, WB_WAIT=0, CNT_W=4, then run 17 non-memory instructions -> 6 cycles each, retired_cnt wraps to 1. Separately, assert rst during a MEM wait -> phase=0 and counters 0 the next cycle.
